edge_toggle_bank: RTL

- Parametrised, multi-channel successor to the single-bit posedge/negedge toggle-register diagnostic logic.
- Per channel: edge detection with a selectable mode, a toggle output, an edge counter, and a sticky pending flag.
- Pending edges are reported through a valid/ready event port, lowest channel first.
- Used as a coverage diagnostic target for toggle, FSM-like and combinational-condition coverage across generate-expanded channels.

---
 rtl/edge_toggle_bank.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/edge_toggle_bank.sv
// ---------------------------------------------------------------------------
// edge_toggle_bank
//   A bank of independent edge monitors. Each channel detects rising and/or
//   falling edges on its input according to a 2-bit mode. On every detected
//   edge the channel inverts its toggle register, bumps its edge counter and
//   raises a sticky pending flag. Pending channels are offered one at a time
//   on a valid/ready event port, lowest channel index first. An edge that
//   arrives while the channel is still pending, and is not being accepted in
//   the same cycle, sets a sticky overflow bit.
//
//   Optional feature (macro EDGE_TOGGLE_SAT_EN):
//     defined   -> edge counters saturate at all-ones
//     undefined -> edge counters wrap modulo 2**CNT_W
//
// Parameters
//   CHANNELS  number of monitored channels (1..16)
//   CNT_W     edge counter width per channel (2..16)
//   CHAN_W    event channel index width, 2**CHAN_W >= CHANNELS
//
// Ports
//   clock      rising-edge clock
//   reset_n    synchronous active-low reset
//   sig_in     monitored inputs, already synchronous to clock
//   mode       per-channel mode, [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr        per-channel clear of toggle, counter, pending and overflow
//   tgl_out    per-channel toggle register
//   cnt_flat   per-channel edge counters, channel i at [CNT_W*i +: CNT_W]
//   evt_valid  an event is offered
//   evt_chan   channel index of the offered event
//   evt_ready  consumer accepts the offered event
//   ovf        sticky per-channel overflow (an edge was lost)
//   all_set    every enabled channel has tgl_out=1, at least one enabled
// ---------------------------------------------------------------------------
module edge_toggle_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int CHAN_W   = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       sig_in,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       clr,
  output logic [CHANNELS-1:0]       tgl_out,
  output logic [CNT_W*CHANNELS-1:0] cnt_flat,
  output logic                      evt_valid,
  output logic [CHAN_W-1:0]         evt_chan,
  input  logic                      evt_ready,
  output logic [CHANNELS-1:0]       ovf,
  output logic                      all_set
);

  logic                r_evt_valid;
  logic [CHAN_W-1:0]   r_evt_chan;
  logic                r_all_set;

  logic [CHANNELS-1:0] w_pending;  // per-channel pending flags
  logic [CHANNELS-1:0] w_sel;      // one-hot of the offered channel
  logic [CHANNELS-1:0] w_acc;      // one-hot of the channel accepted this cycle
  logic [CHANNELS-1:0] w_arb;      // pending set still standing after this cycle's accept/clear
  logic [CHANNELS-1:0] w_en;       // channel has a non-off mode
  logic [CHAN_W-1:0]   w_low;      // lowest index in w_arb
  logic                w_rearb;    // event port may pick a new channel

  // -------------------------------------------------------------------------
  // Per-channel edge detection, toggle, counter, pending and overflow
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic             r_prev;
    logic             r_tgl;
    logic             r_pend;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;
    logic             w_fall;
    logic             w_edge;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_rise = sig_in[g] & ~r_prev;
    assign w_fall = ~sig_in[g] & r_prev;
    assign w_edge = (mode[2*g] & w_rise) | (mode[2*g+1] & w_fall);

`ifdef EDGE_TOGGLE_SAT_EN
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
`else
    assign w_cnt_inc = r_cnt + CNT_W'(1);
`endif

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
      // prev tracks sig_in even during reset, so release sees no false edge.
      r_prev <= sig_in[g];
      if (!reset_n) begin
        r_tgl  <= 1'b0;
        r_cnt  <= '0;
        r_pend <= 1'b0;
        r_ovf  <= 1'b0;
      end else if (clr[g]) begin
        r_tgl  <= 1'b0;
        r_cnt  <= '0;
        r_pend <= 1'b0;
        r_ovf  <= 1'b0;
      end else if (w_edge) begin
        r_tgl  <= ~r_tgl;
        r_cnt  <= w_cnt_inc;
        // A new edge wins over a simultaneous accept; only an edge landing on
        // a pending flag that is not being drained loses information.
        r_pend <= 1'b1;
        if (r_pend && !w_acc[g]) r_ovf <= 1'b1;
      end else if (w_acc[g]) begin
        r_pend <= 1'b0;
      end
    end

    assign tgl_out[g]                   = r_tgl;
    assign cnt_flat[CNT_W*g +: CNT_W]   = r_cnt;
    assign w_pending[g]                 = r_pend;
    assign ovf[g]                       = r_ovf;
  end

  // -------------------------------------------------------------------------
  // Event port arbitration
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path leaves
    // it unassigned and no latch is inferred.
    w_sel = '0;
    w_en  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_sel[i] = (r_evt_chan == CHAN_W'(i));
      w_en[i]  = mode[2*i] | mode[2*i+1];
    end
  end

  assign w_acc = w_sel & {CHANNELS{r_evt_valid & evt_ready}};
  // The accepted or cleared channel must not be re-offered on its stale flag.
  assign w_arb = w_pending & ~w_acc & ~clr;

  always_comb begin
    w_low = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_arb[i]) w_low = CHAN_W'(i);
    end
  end

  // A stalled offer is held; it is replaced only when idle, accepted, or
  // when the offered channel is cleared underneath it.
  assign w_rearb = !r_evt_valid || evt_ready || |(clr & w_sel);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_evt_valid <= 1'b0;
      r_evt_chan  <= '0;
      r_all_set   <= 1'b0;
    end else begin
      if (w_rearb) begin
        r_evt_valid <= |w_arb;
        r_evt_chan  <= w_low;
      end
      r_all_set <= (|w_en) && ((w_en & ~tgl_out) == '0);
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_chan  = r_evt_chan;
  assign all_set   = r_all_set;

endmodule
